// File: rtl/rgb_stream_if.sv
// Pixel stream bundle: input beat side plus converted RGB output side.
// slave is the converter's view, master is the view of the logic around it.
interface rgb_stream_if #(parameter int OUT_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      Din;
  logic             Nblank;
  logic             sof;
  logic             eol;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] R;
  logic [OUT_W-1:0] G;
  logic [OUT_W-1:0] B;
  logic             out_sof;
  logic             out_eol;

  modport slave (
    input  in_valid, Din, Nblank, sof, eol, out_ready,
    output in_ready, out_valid, R, G, B, out_sof, out_eol
  );

  modport master (
    output in_valid, Din, Nblank, sof, eol, out_ready,
    input  in_ready, out_valid, R, G, B, out_sof, out_eol
  );
endinterface

// File: rtl/rgb_stream_conv.sv
// RGB565/555/444/GRAY8 to OUT_W-per-channel expander with optional luma output.
// Two-stage elastic pipe: S1 holds expanded channels, S2 holds the final RGB.
module rgb_stream_conv #(
  parameter int OUT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode_i,
  input  logic       gray_en_i,
  rgb_stream_if.slave st
);

  // Repeat the w-bit channel MSB-first, then keep the top OUT_W bits.
  function automatic logic [OUT_W-1:0] expand(input logic [7:0] c, input int w);
    logic [OUT_W+7:0] acc;
    int               n;
    acc = '0;
    n   = 0;
    for (int k = 0; k < OUT_W; k += w) begin
      acc = (acc << w) | (OUT_W+8)'(c);
      n   = n + w;
    end
    acc = acc >> (n - OUT_W);
    return acc[OUT_W-1:0];
  endfunction

  logic [1:0]       mode_q;
  logic             gray_q;
  logic [1:0]       mode_eff;
  logic             gray_eff;
  logic             accept;
  logic             s2_load;

  logic             s1_valid;
  logic [OUT_W-1:0] s1_r, s1_g, s1_b;
  logic             s1_nblank, s1_sof, s1_eol, s1_gray;
  logic [OUT_W-1:0] x_r, x_g, x_b;

  logic             s2_valid;
  logic [OUT_W-1:0] s2_r, s2_g, s2_b;
  logic             s2_sof, s2_eol;
  logic [OUT_W+7:0] y_sum;
  logic [OUT_W-1:0] y;
  logic [OUT_W-1:0] f_r, f_g, f_b;

  assign s2_load     = s1_valid & (~s2_valid | st.out_ready);
  assign st.in_ready = ~s1_valid | s2_load;
  assign accept      = st.in_valid & st.in_ready;

  // A sof beat takes its own settings immediately, so a frame never mixes formats.
  always_comb begin
    mode_eff = mode_q;
    gray_eff = gray_q;
    if (accept && st.sof) begin
      mode_eff = mode_i;
      gray_eff = gray_en_i;
    end
  end

  always_comb begin
    x_r = '0;
    x_g = '0;
    x_b = '0;
    case (mode_eff)
      2'd0: begin
        x_r = expand({3'b000, st.Din[15:11]}, 5);
        x_g = expand({2'b00,  st.Din[10:5]},  6);
        x_b = expand({3'b000, st.Din[4:0]},   5);
      end
      2'd1: begin
        x_r = expand({3'b000, st.Din[14:10]}, 5);
        x_g = expand({3'b000, st.Din[9:5]},   5);
        x_b = expand({3'b000, st.Din[4:0]},   5);
      end
      2'd2: begin
        x_r = expand({4'h0, st.Din[11:8]}, 4);
        x_g = expand({4'h0, st.Din[7:4]},  4);
        x_b = expand({4'h0, st.Din[3:0]},  4);
      end
      default: begin
        x_r = expand(st.Din[7:0], 8);
        x_g = x_r;
        x_b = x_r;
      end
    endcase
  end

  // Weights sum to 256, so all-ones channels give all-ones luma without overflow.
  always_comb begin
    y_sum = (OUT_W+8)'(s1_r) * (OUT_W+8)'(77)
          + (OUT_W+8)'(s1_g) * (OUT_W+8)'(150)
          + (OUT_W+8)'(s1_b) * (OUT_W+8)'(29);
    y     = y_sum[OUT_W+7:8];
    f_r   = s1_gray ? y : s1_r;
    f_g   = s1_gray ? y : s1_g;
    f_b   = s1_gray ? y : s1_b;
    if (!s1_nblank) begin
      f_r = '0;
      f_g = '0;
      f_b = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= 2'd0;
      gray_q    <= 1'b0;
      s1_valid  <= 1'b0;
      s1_r      <= '0;
      s1_g      <= '0;
      s1_b      <= '0;
      s1_nblank <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eol    <= 1'b0;
      s1_gray   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_r      <= '0;
      s2_g      <= '0;
      s2_b      <= '0;
      s2_sof    <= 1'b0;
      s2_eol    <= 1'b0;
    end else begin
      if (accept) begin
        mode_q    <= mode_eff;
        gray_q    <= gray_eff;
        s1_r      <= x_r;
        s1_g      <= x_g;
        s1_b      <= x_b;
        s1_nblank <= st.Nblank;
        s1_sof    <= st.sof;
        s1_eol    <= st.eol;
        s1_gray   <= gray_eff;
      end
      s1_valid <= accept | (s1_valid & ~s2_load);
      s2_valid <= s2_load | (s2_valid & ~st.out_ready);
      if (s2_load) begin
        s2_r   <= f_r;
        s2_g   <= f_g;
        s2_b   <= f_b;
        s2_sof <= s1_sof;
        s2_eol <= s1_eol;
      end
    end
  end

  assign st.out_valid = s2_valid;
  assign st.R         = s2_r;
  assign st.G         = s2_g;
  assign st.B         = s2_b;
  assign st.out_sof   = s2_sof;
  assign st.out_eol   = s2_eol;

endmodule

// File: tb/tb_rgb_stream_conv.sv
// Scoreboard bench for rgb_stream_conv: directed cases then randomized traffic
// against a bit-level reference model of the format rules.
module tb_rgb_stream_conv;
  localparam int OUT_W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       gray_en;

  rgb_stream_if #(.OUT_W(OUT_W)) st ();

  rgb_stream_conv #(.OUT_W(OUT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_i    (mode),
    .gray_en_i (gray_en),
    .st        (st.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] r, g, b;
    logic             sof, eol;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   m_mode = 0;
  bit   m_gray = 0;
  bit   rand_rdy = 0;
  logic [OUT_W-1:0] last_r, last_g, last_b;
  logic             last_sof, last_eol;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output bit i is input bit (w-1 - i mod w): MSB-first repetition.
  function automatic int expand_ref(input int c, input int w);
    int e;
    e = 0;
    for (int i = 0; i < OUT_W; i++) e = e * 2 + ((c >> (w - 1 - (i % w))) & 1);
    return e;
  endfunction

  function automatic exp_t model(input int d, input bit nb, input bit s, input bit e);
    exp_t x;
    int   r, g, b, y;
    case (m_mode)
      0: begin r = expand_ref((d >> 11) & 31, 5); g = expand_ref((d >> 5) & 63, 6); b = expand_ref(d & 31, 5); end
      1: begin r = expand_ref((d >> 10) & 31, 5); g = expand_ref((d >> 5) & 31, 5); b = expand_ref(d & 31, 5); end
      2: begin r = expand_ref((d >> 8) & 15, 4);  g = expand_ref((d >> 4) & 15, 4); b = expand_ref(d & 15, 4); end
      default: begin r = expand_ref(d & 255, 8); g = r; b = r; end
    endcase
    if (m_gray) begin
      y = (77 * r + 150 * g + 29 * b) / 256;
      r = y; g = y; b = y;
    end
    if (!nb) begin r = 0; g = 0; b = 0; end
    x.r = OUT_W'(r); x.g = OUT_W'(g); x.b = OUT_W'(b);
    x.sof = s; x.eol = e;
    return x;
  endfunction

  // Call aligned to posedge+#1; returns aligned to posedge+#1 after the accepting edge.
  task automatic send(input logic [15:0] d, input logic [1:0] m, input bit g,
                      input bit nb, input bit s, input bit e);
    bit acc;
    int t;
    acc = 0;
    t   = 0;
    st.in_valid = 1'b1;
    st.Din      = d;
    st.Nblank   = nb;
    st.sof      = s;
    st.eol      = e;
    mode        = m;
    gray_en     = g;
    while (!acc) begin
      @(negedge clk);
      if (st.in_ready) begin
        if (s) begin m_mode = int'(m); m_gray = g; end
        sb.push_back(model(int'(d), nb, s, e));
        n_acc++;
        acc = 1;
      end
      @(posedge clk);
      #1;
      t++;
      if (!acc && t > 60) begin
        check("send_timeout", 32'(t), 32'd0);
        break;
      end
    end
    st.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) st.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  initial begin
    exp_t                 e;
    bit                   held;
    logic [3*OUT_W+1:0]   held_v;
    held = 0;
    held_v = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 0;
      end else begin
        if (held && st.out_valid)
          check("stall_stable", 32'({st.R, st.G, st.B, st.out_sof, st.out_eol}), 32'(held_v));
        if (held && !st.out_valid)
          check("stall_valid_drop", 32'(st.out_valid), 32'd1);
        if (st.out_valid && st.out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_beat", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check("R", 32'(st.R), 32'(e.r));
            check("G", 32'(st.G), 32'(e.g));
            check("B", 32'(st.B), 32'(e.b));
            check("out_sof", 32'(st.out_sof), 32'(e.sof));
            check("out_eol", 32'(st.out_eol), 32'(e.eol));
          end
          last_r = st.R; last_g = st.G; last_b = st.B;
          last_sof = st.out_sof; last_eol = st.out_eol;
        end
        held   = st.out_valid && !st.out_ready;
        held_v = {st.R, st.G, st.B, st.out_sof, st.out_eol};
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    reset        = 1'b1;
    mode         = 2'd0;
    gray_en      = 1'b0;
    st.in_valid  = 1'b0;
    st.Din       = '0;
    st.Nblank    = 1'b1;
    st.sof       = 1'b0;
    st.eol       = 1'b0;
    st.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 32'(st.out_valid), 32'd0);
    check("rst_R", 32'(st.R), 32'd0);
    check("rst_G", 32'(st.G), 32'd0);
    check("rst_B", 32'(st.B), 32'd0);
    check("rst_out_sof", 32'(st.out_sof), 32'd0);
    check("rst_out_eol", 32'(st.out_eol), 32'd0);
    check("rst_in_ready", 32'(st.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Pure red in RGB565, plus the two-cycle latency.
    send(16'hF800, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("lat_not_yet", 32'(st.out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(st.out_valid), 32'd1);
    check("red_R", 32'(st.R), 32'hFF);
    check("red_G", 32'(st.G), 32'h00);
    check("red_B", 32'(st.B), 32'h00);
    @(posedge clk);
    #1;

    send(16'h07E0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    drain();
    check("luma_R", 32'(last_r), 32'h95);
    check("luma_G", 32'(last_g), 32'h95);
    check("luma_B", 32'(last_b), 32'h95);

    // mode_i change without sof must not take effect.
    send(16'h0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    send(16'h00AB, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    check("nosof_R", 32'(last_r), 32'h00);
    check("nosof_G", 32'(last_g), 32'h14);
    check("nosof_B", 32'(last_b), 32'h5A);
    send(16'h00AB, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();
    check("gray8_R", 32'(last_r), 32'hAB);
    check("gray8_G", 32'(last_g), 32'hAB);
    check("gray8_B", 32'(last_b), 32'hAB);

    // Backpressure: only two beats may be held while out_ready is low.
    st.out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(16'(i * 16'h1111 + 16'h0101), 2'd3, 1'b0, 1'b1, i == 0, i == 5);
      end
      begin
        repeat (4) @(negedge clk);
        check("stall_held", 32'(n_acc - base), 32'd2);
        check("stall_in_ready", 32'(st.in_ready), 32'd0);
        @(posedge clk);
        #1 st.out_ready = 1'b1;
      end
    join
    drain();
    check("stall_all_out", 32'(n_acc - base), 32'd6);

    send(16'hFFFF, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    check("blank_R", 32'(last_r), 32'h00);
    check("blank_G", 32'(last_g), 32'h00);
    check("blank_B", 32'(last_b), 32'h00);
    check("blank_eol", 32'(last_eol), 32'd1);

    // Reset with two beats in flight; settings must return to RGB565, no gray.
    st.out_ready = 1'b0;
    send(16'h1234, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    send(16'h5678, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    sb.delete();
    m_mode = 0;
    m_gray = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(st.out_valid), 32'd0);
    check("midrst_in_ready", 32'(st.in_ready), 32'd1);
    @(posedge clk);
    #1 st.out_ready = 1'b1;
    send(16'hF800, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    check("postrst_R", 32'(last_r), 32'hFF);
    check("postrst_G", 32'(last_g), 32'h00);
    check("postrst_B", 32'(last_b), 32'h00);

    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 st.out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
